// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port byte-addressed RAM between the
// instruction-fetch port (F, word reads only) and the load/store port (D).
// Each access is a registered IDLE -> ACCESS -> DONE transaction. Misaligned
// or illegal accesses skip ACCESS and report an error without touching RAM.
//
// Ports:
//   Clk, Reset              clock (rising edge), asynchronous active-high reset
//   FReq/FAddr              fetch request and byte address
//   FAck/FData/FErr         fetch completion pulse, fetched word, error pulse
//   DReq/DWrite/DAddr/DSize load/store request, direction, address, size
//   DSigned/DWrData         narrow-load sign request, store data
//   DAck/DRdData/DErr       load/store completion pulse, load result, error pulse
//   Mem*                    RAM interface (Enable, ReadWrite, Address, Size,
//                           DataIn, DataOut with combinational read)
//   Busy                    high whenever a transaction is in progress
//
// Optional feature: define MEM_SIGNEXT_EN to sign-extend byte/halfword loads
// issued with DSigned=1. Without it, narrow loads are always zero-extended.

module mem_port_arbiter #(
    parameter int unsigned ADDR_W           = 8,
    parameter int unsigned FETCH_STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FReq,
    input  logic [ADDR_W-1:0] FAddr,
    output logic              FAck,
    output logic [31:0]       FData,
    output logic              FErr,
    input  logic              DReq,
    input  logic              DWrite,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [1:0]        DSize,
    input  logic              DSigned,
    input  logic [31:0]       DWrData,
    output logic              DAck,
    output logic [31:0]       DRdData,
    output logic              DErr,
    output logic              MemEnable,
    output logic              MemReadWrite,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [1:0]        MemSize,
    output logic [31:0]       MemDataIn,
    input  logic [31:0]       MemDataOut,
    output logic              Busy
);

    localparam logic [3:0] StarveMax = 4'(FETCH_STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e              state_q, state_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]          mem_size_q, mem_size_d;
    logic [31:0]         mem_din_q, mem_din_d;
    logic                grant_f_q, grant_f_d;
    logic                d_signed_q, d_signed_d;
    logic                f_ack_q, f_ack_d, f_err_q, f_err_d;
    logic                d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [31:0]         f_data_q, f_data_d;
    logic [31:0]         d_rd_data_q, d_rd_data_d;
    logic [3:0]          starve_q, starve_d;

    logic                win_f, f_legal, d_legal, legal;
    logic                ext_b, ext_h;
    logic [31:0]         load_fmt;

    // D wins unless it is absent or F has been starved for the maximum run.
    assign win_f   = FReq && (!DReq || (starve_q == StarveMax));
    assign f_legal = (FAddr[1:0] == 2'b00);

    always_comb begin
        d_legal = 1'b0;
        case (DSize)
            2'b00:   d_legal = 1'b1;
            2'b01:   d_legal = !DAddr[0];
            2'b10:   d_legal = (DAddr[1:0] == 2'b00);
            default: d_legal = 1'b0;
        endcase
    end

    assign legal = win_f ? f_legal : d_legal;

`ifdef MEM_SIGNEXT_EN
    assign ext_b = d_signed_q && MemDataOut[7];
    assign ext_h = d_signed_q && MemDataOut[15];
`else
    logic unused_dsigned;
    assign unused_dsigned = d_signed_q;
    assign ext_b = 1'b0;
    assign ext_h = 1'b0;
`endif

    always_comb begin
        load_fmt = MemDataOut;
        case (mem_size_q)
            2'b00:   load_fmt = {{24{ext_b}}, MemDataOut[7:0]};
            2'b01:   load_fmt = {{16{ext_h}}, MemDataOut[15:0]};
            default: load_fmt = MemDataOut;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_size_d  = mem_size_q;
        mem_din_d   = mem_din_q;
        grant_f_d   = grant_f_q;
        d_signed_d  = d_signed_q;
        f_ack_d     = f_ack_q;
        f_err_d     = f_err_q;
        d_ack_d     = d_ack_q;
        d_err_d     = d_err_q;
        f_data_d    = f_data_q;
        d_rd_data_d = d_rd_data_q;
        starve_d    = starve_q;

        case (state_q)
            StIdle: begin
                if (FReq || DReq) begin
                    grant_f_d = win_f;
                    if (win_f) begin
                        mem_addr_d = FAddr;
                        mem_size_d = 2'b10;
                        mem_din_d  = 32'h0;
                        mem_rw_d   = 1'b0;
                        d_signed_d = 1'b0;
                    end else begin
                        mem_addr_d = DAddr;
                        mem_size_d = DSize;
                        mem_din_d  = DWrData;
                        mem_rw_d   = legal && DWrite;
                        d_signed_d = DSigned;
                    end
                    mem_en_d = legal;
                    if (legal) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StDone;
                        f_err_d = win_f;
                        d_err_d = !win_f;
                    end
                    // Error transactions count as grants for fairness.
                    if (win_f || !FReq) begin
                        starve_d = 4'd0;
                    end else if (starve_q != StarveMax) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            StAccess: begin
                mem_en_d = 1'b0;
                mem_rw_d = 1'b0;
                state_d  = StDone;
                if (grant_f_q) begin
                    f_ack_d  = 1'b1;
                    f_data_d = MemDataOut;
                end else begin
                    d_ack_d = 1'b1;
                    if (!mem_rw_q) begin
                        d_rd_data_d = load_fmt;
                    end
                end
            end
            StDone: begin
                f_ack_d = 1'b0;
                f_err_d = 1'b0;
                d_ack_d = 1'b0;
                d_err_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_size_q  <= 2'b00;
            mem_din_q   <= 32'h0;
            grant_f_q   <= 1'b0;
            d_signed_q  <= 1'b0;
            f_ack_q     <= 1'b0;
            f_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            f_data_q    <= 32'h0;
            d_rd_data_q <= 32'h0;
            starve_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_size_q  <= mem_size_d;
            mem_din_q   <= mem_din_d;
            grant_f_q   <= grant_f_d;
            d_signed_q  <= d_signed_d;
            f_ack_q     <= f_ack_d;
            f_err_q     <= f_err_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            f_data_q    <= f_data_d;
            d_rd_data_q <= d_rd_data_d;
            starve_q    <= starve_d;
        end
    end

    assign FAck         = f_ack_q;
    assign FErr         = f_err_q;
    assign FData        = f_data_q;
    assign DAck         = d_ack_q;
    assign DErr         = d_err_q;
    assign DRdData      = d_rd_data_q;
    assign MemEnable    = mem_en_q;
    assign MemReadWrite = mem_rw_q;
    assign MemAddress   = mem_addr_q;
    assign MemSize      = mem_size_q;
    assign MemDataIn    = mem_din_q;
    assign Busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: big-endian RAM model, vector table of D-port
// transactions, plus sequences for fetch, contention and reset mid-access.

module tb_mem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        FReq;
    logic [7:0]  FAddr;
    logic        FAck;
    logic [31:0] FData;
    logic        FErr;
    logic        DReq;
    logic        DWrite;
    logic [7:0]  DAddr;
    logic [1:0]  DSize;
    logic        DSigned;
    logic [31:0] DWrData;
    logic        DAck;
    logic [31:0] DRdData;
    logic        DErr;
    logic        MemEnable;
    logic        MemReadWrite;
    logic [7:0]  MemAddress;
    logic [1:0]  MemSize;
    logic [31:0] MemDataIn;
    logic [31:0] MemDataOut;
    logic        Busy;

    mem_port_arbiter #(
        .ADDR_W           (8),
        .FETCH_STARVE_MAX (4)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .FReq         (FReq),
        .FAddr        (FAddr),
        .FAck         (FAck),
        .FData        (FData),
        .FErr         (FErr),
        .DReq         (DReq),
        .DWrite       (DWrite),
        .DAddr        (DAddr),
        .DSize        (DSize),
        .DSigned      (DSigned),
        .DWrData      (DWrData),
        .DAck         (DAck),
        .DRdData      (DRdData),
        .DErr         (DErr),
        .MemEnable    (MemEnable),
        .MemReadWrite (MemReadWrite),
        .MemAddress   (MemAddress),
        .MemSize      (MemSize),
        .MemDataIn    (MemDataIn),
        .MemDataOut   (MemDataOut),
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    // RAM model: big-endian, combinational read. Narrow reads put filler in
    // the unused upper bits so that missing masking in the DUT is visible.
    logic [7:0] mem [256];
    logic       mem_clear;
    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        a0 = MemAddress;
        a1 = MemAddress + 8'd1;
        a2 = MemAddress + 8'd2;
        a3 = MemAddress + 8'd3;
        case (MemSize)
            2'b00:   MemDataOut = {24'hA5A5A5, mem[a0]};
            2'b01:   MemDataOut = {16'hA5A5, mem[a0], mem[a1]};
            default: MemDataOut = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    always @(posedge Clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (MemEnable && MemReadWrite) begin
            case (MemSize)
                2'b00: mem[a0] <= MemDataIn[7:0];
                2'b01: begin
                    mem[a0] <= MemDataIn[15:8];
                    mem[a1] <= MemDataIn[7:0];
                end
                default: begin
                    mem[a0] <= MemDataIn[31:24];
                    mem[a1] <= MemDataIn[23:16];
                    mem[a2] <= MemDataIn[15:8];
                    mem[a3] <= MemDataIn[7:0];
                end
            endcase
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

`ifdef MEM_SIGNEXT_EN
    localparam logic [31:0] ExpHalfS = 32'hFFFF80F0;
    localparam logic [31:0] ExpByteS = 32'hFFFFFF80;
`else
    localparam logic [31:0] ExpHalfS = 32'h000080F0;
    localparam logic [31:0] ExpByteS = 32'h00000080;
`endif

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wd;
        logic        exp_err;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NumVec = 16;
    vec_t vecs [NumVec];

    // Runs one D transaction from IDLE; returns outcome, edges to completion,
    // whether MemEnable or an F pulse was seen, then waits for IDLE again.
    task automatic d_txn(input logic wr, input logic [7:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wd,
                         output logic got_ack, output logic got_err, output int lat,
                         output logic saw_en, output logic saw_f);
        DReq = 1'b1; DWrite = wr; DAddr = addr; DSize = size; DSigned = sgn; DWrData = wd;
        got_ack = 1'b0; got_err = 1'b0; lat = 0; saw_en = 1'b0; saw_f = 1'b0;
        while (lat < 10 && !got_ack && !got_err) begin
            @(posedge Clk); #1;
            lat++;
            if (MemEnable) saw_en = 1'b1;
            if (FAck || FErr) saw_f = 1'b1;
            got_ack = DAck;
            got_err = DErr;
        end
        DReq = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic f_txn(input logic [7:0] addr,
                         output logic got_ack, output logic got_err, output int lat,
                         output logic saw_en, output logic saw_d);
        FReq = 1'b1; FAddr = addr;
        got_ack = 1'b0; got_err = 1'b0; lat = 0; saw_en = 1'b0; saw_d = 1'b0;
        while (lat < 10 && !got_ack && !got_err) begin
            @(posedge Clk); #1;
            lat++;
            if (MemEnable) saw_en = 1'b1;
            if (DAck || DErr) saw_d = 1'b1;
            got_ack = FAck;
            got_err = FErr;
        end
        FReq = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack, err, en, other;
        int   lat;
        logic seq [10];
        logic exp_seq [10];
        int   n, cyc, both;

        //        wr    addr   size  sgn   wdata          err   chk   data
        vecs[0]  = '{1'b1, 8'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 8'h10, 2'b10, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 8'h11, 2'b00, 1'b0, 32'h0,        1'b0, 1'b1, 32'h000000AD};
        vecs[3]  = '{1'b0, 8'h12, 2'b01, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000BEEF};
        vecs[4]  = '{1'b1, 8'h13, 2'b10, 1'b0, 32'h11223344, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 8'h11, 2'b01, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 8'h10, 2'b11, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 8'h14, 2'b00, 1'b0, 32'h1234565A, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 8'h14, 2'b10, 1'b0, 32'h0,        1'b0, 1'b1, 32'h5A000000};
        vecs[9]  = '{1'b1, 8'h16, 2'b01, 1'b0, 32'hFFFF1234, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 8'h14, 2'b10, 1'b0, 32'h0,        1'b0, 1'b1, 32'h5A001234};
        vecs[11] = '{1'b1, 8'h20, 2'b10, 1'b0, 32'h80F00000, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 8'h20, 2'b01, 1'b1, 32'h0,        1'b0, 1'b1, ExpHalfS};
        vecs[13] = '{1'b0, 8'h20, 2'b00, 1'b1, 32'h0,        1'b0, 1'b1, ExpByteS};
        vecs[14] = '{1'b0, 8'h21, 2'b00, 1'b0, 32'h0,        1'b0, 1'b1, 32'h000000F0};
        vecs[15] = '{1'b0, 8'h10, 2'b10, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};

        Reset = 1'b1; mem_clear = 1'b1;
        FReq = 1'b0; FAddr = 8'h0;
        DReq = 1'b0; DWrite = 1'b0; DAddr = 8'h0; DSize = 2'b00; DSigned = 1'b0;
        DWrData = 32'h0;
        repeat (3) @(posedge Clk);
        mem_clear = 1'b0;
        #1;
        check32("reset FData", FData, 32'h0);
        check32("reset DRdData", DRdData, 32'h0);
        check32("reset MemDataIn", MemDataIn, 32'h0);
        check32("reset ctl", {17'h0, FAck, FErr, DAck, DErr, MemEnable, MemReadWrite,
                              MemAddress, MemSize, Busy}, 32'h0);
        @(negedge Clk) Reset = 1'b0;
        @(posedge Clk); #1;

        for (int i = 0; i < NumVec; i++) begin
            d_txn(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].wd,
                  ack, err, lat, en, other);
            check32($sformatf("vec%0d outcome", i), {30'h0, ack, err},
                    vecs[i].exp_err ? 32'd1 : 32'd2);
            check32($sformatf("vec%0d latency", i), lat, vecs[i].exp_err ? 32'd1 : 32'd2);
            check32($sformatf("vec%0d mem_enable_seen", i), {31'h0, en},
                    {31'h0, !vecs[i].exp_err});
            check32($sformatf("vec%0d f_pulse_seen", i), {31'h0, other}, 32'h0);
            if (vecs[i].chk_data) begin
                check32($sformatf("vec%0d data", i), DRdData, vecs[i].exp_data);
            end
            check32($sformatf("vec%0d idle_after", i), {30'h0, Busy, DAck}, 32'h0);
        end

        f_txn(8'h10, ack, err, lat, en, other);
        check32("fetch outcome", {30'h0, ack, err}, 32'd2);
        check32("fetch latency", lat, 32'd2);
        check32("fetch data", FData, 32'hDEADBEEF);
        check32("fetch d_pulse_seen", {31'h0, other}, 32'h0);
        f_txn(8'h02, ack, err, lat, en, other);
        check32("fetch misaligned outcome", {30'h0, ack, err}, 32'd1);
        check32("fetch misaligned latency", lat, 32'd1);
        check32("fetch misaligned mem_enable_seen", {31'h0, en}, 32'h0);
        check32("fetch data held", FData, 32'hDEADBEEF);

        // Contention: both ports held; grants must follow D x4, F, D x4, F.
        for (int i = 0; i < 10; i++) exp_seq[i] = (i == 4 || i == 9);
        FReq = 1'b1; FAddr = 8'h10;
        DReq = 1'b1; DWrite = 1'b0; DAddr = 8'h14; DSize = 2'b10; DSigned = 1'b0;
        n = 0; cyc = 0; both = 0;
        while (n < 10 && cyc < 80) begin
            @(posedge Clk); #1;
            cyc++;
            if (FAck && DAck) both++;
            if (FAck || DAck) begin
                seq[n] = FAck;
                n++;
            end
        end
        FReq = 1'b0; DReq = 1'b0;
        check32("contention grant count", n, 32'd10);
        check32("contention both acks", both, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (i < n) check32($sformatf("contention grant%0d is_f", i), {31'h0, seq[i]},
                               {31'h0, exp_seq[i]});
        end
        check32("contention fdata", FData, 32'hDEADBEEF);
        check32("contention ddata", DRdData, 32'h5A001234);
        @(posedge Clk); #1;
        check32("contention idle_after", {31'h0, Busy}, 32'h0);

        // Reset in the ACCESS cycle of a store.
        DReq = 1'b1; DWrite = 1'b1; DAddr = 8'h30; DSize = 2'b10; DWrData = 32'hCAFEF00D;
        @(posedge Clk); #1;
        check32("abort store in access", {30'h0, MemEnable, MemReadWrite}, 32'd3);
        #2 Reset = 1'b1;
        #1;
        check32("abort mem_enable async", {31'h0, MemEnable}, 32'h0);
        check32("abort ctl", {23'h0, FAck, FErr, DAck, DErr, MemEnable, MemReadWrite,
                              MemSize, Busy}, 32'h0);
        check32("abort DRdData", DRdData, 32'h0);
        check32("abort FData", FData, 32'h0);
        DReq = 1'b0;
        @(posedge Clk); #1;
        check32("abort no write", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, 32'h0);
        check32("abort no ack", {30'h0, DAck, DErr}, 32'h0);
        @(negedge Clk) Reset = 1'b0;
        @(posedge Clk); #1;
        d_txn(1'b1, 8'h30, 2'b10, 1'b0, 32'hCAFEF00D, ack, err, lat, en, other);
        check32("post reset store outcome", {30'h0, ack, err}, 32'd2);
        check32("post reset store latency", lat, 32'd2);
        d_txn(1'b0, 8'h30, 2'b10, 1'b0, 32'h0, ack, err, lat, en, other);
        check32("post reset load outcome", {30'h0, ack, err}, 32'd2);
        check32("post reset load data", DRdData, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
